// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Operands are latched at launch; the result is written after a fixed busy period.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } md_req_t;

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  md_req_t            req;

  logic               is_div, is_signed, div_zero, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_mag, rem_mag, quo, rem;
  logic [2*WIDTH-1:0] prod_mag, prod;

  // Sign-magnitude datapath: the most negative dividend over -1 falls out
  // naturally as a wrapped quotient with zero remainder.
  always_comb begin
    is_div    = req.op[1];
    is_signed = ~req.op[0];
    div_zero  = (req.b == '0);
    a_neg     = is_signed & req.a[WIDTH-1];
    b_neg     = is_signed & req.b[WIDTH-1];
    a_mag     = a_neg ? -req.a : req.a;
    b_mag     = b_neg ? -req.b : req.b;
    prod_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    prod      = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
    quo_mag   = div_zero ? '0 : a_mag / b_mag;
    rem_mag   = div_zero ? '0 : a_mag % b_mag;
    quo       = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem       = a_neg ? -rem_mag : rem_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      req   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // cancel in IDLE squashes both a launch and any MTHI/MTLO
          if (!cancel) begin
            if (start) begin
              req.op <= op;
              req.a  <= a;
              req.b  <= b;
              cnt    <= op[1] ? DIV_N : MULT_N;
              state  <= S_BUSY;
            end else begin
              if (we_hi) hi <= wdata;
              if (we_lo) lo <= wdata;
            end
          end
        end
        default: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state <= S_IDLE;
              if (!is_div) begin
                {hi, lo} <= prod;
              end else if (!div_zero) begin
                hi <= rem;
                lo <= quo;
              end
            end
          end
        end
      endcase
    end
  end

  assign busy = (state == S_BUSY);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: default instance plus a MULT_CYCLES=1 /
// DIV_CYCLES=33 instance for the latency sweep.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, start1, we_hi, we_lo, cancel;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy0, busy1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int checks = 0;
  int errors = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] mdl0, mdl1;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata), .cancel(cancel),
    .busy(busy0), .hi(hi0), .lo(lo0)
  );

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(33)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata), .cancel(cancel),
    .busy(busy1), .hi(hi1), .lo(lo1)
  );

  // Reference model: 64-bit arithmetic, {hi,lo}; cur is returned on divide by zero
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb, input logic [63:0] cur);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'h0, ma};
    ub = {32'h0, mb};
    case (mop)
      2'b00: return 64'(sa * sb);
      2'b01: return 64'(ua * ub);
      2'b10: begin
        if (mb == 32'h0) return cur;
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (mb == 32'h0) return cur;
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input bit sel, input logic [1:0] lop, input logic [31:0] la,
                        input logic [31:0] lb);
    op = lop; a = la; b = lb;
    if (sel) begin
      start1 = 1'b1;
      q1.push_back(model(lop, la, lb, mdl1));
    end else begin
      start = 1'b1;
      q0.push_back(model(lop, la, lb, mdl0));
    end
    tick();
    start = 1'b0; start1 = 1'b0;
  endtask

  // Counts busy cycles (continuing from pre), then pops and compares the result
  task automatic wait_done(input bit sel, input int n_exp, input int pre, input string name);
    int          cnt;
    logic [63:0] exp;
    cnt = pre;
    while ((sel ? busy1 : busy0) && cnt < 200) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== n_exp) begin
      errors++;
      $display("FAIL %s_cycles: got %0d expected %0d", name, cnt, n_exp);
    end
    if (sel) begin
      exp = q1.pop_front();
      mdl1 = exp;
      chk({name, "_hi"}, hi1, exp[63:32]);
      chk({name, "_lo"}, lo1, exp[31:0]);
    end else begin
      exp = q0.pop_front();
      mdl0 = exp;
      chk({name, "_hi"}, hi0, exp[63:32]);
      chk({name, "_lo"}, lo0, exp[31:0]);
    end
  endtask

  task automatic write_hilo(input bit whi, input bit wlo, input logic [31:0] d);
    we_hi = whi; we_lo = wlo; wdata = d;
    tick();
    we_hi = 1'b0; we_lo = 1'b0;
    if (whi) mdl0[63:32] = d;
    if (wlo) mdl0[31:0] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl0 = '0; mdl1 = '0;
    q0.delete(); q1.delete();
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_hi", hi0, 32'h0);
    chk("rst_lo", lo0, 32'h0);
    write_hilo(1'b1, 1'b1, 32'h5A5A5A5A);
    launch(1'b0, 2'b10, 32'd1000, 32'd3);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl0 = '0;
    q0.delete();
    chk("rst_mid_busy", {31'h0, busy0}, 32'h0);
    chk("rst_mid_hi", hi0, 32'h0);
    chk("rst_mid_lo", lo0, 32'h0);
    launch(1'b0, 2'b01, 32'd3, 32'd4);
    wait_done(1'b0, 5, 0, "post_rst");
  endtask

  task automatic test_mult();
    launch(1'b0, 2'b00, 32'hFFFFFFFE, 32'h3);
    wait_done(1'b0, 5, 0, "mult");
    chk("mult_hi_const", hi0, 32'hFFFFFFFF);
    chk("mult_lo_const", lo0, 32'hFFFFFFFA);
    launch(1'b0, 2'b01, 32'hFFFFFFFE, 32'h3);
    wait_done(1'b0, 5, 0, "multu");
    chk("multu_hi_const", hi0, 32'h00000002);
    launch(1'b0, 2'b00, 32'h80000000, 32'h80000000);
    wait_done(1'b0, 5, 0, "mult_minsq");
  endtask

  task automatic test_div();
    launch(1'b0, 2'b10, 32'hFFFFFFF9, 32'h2);
    wait_done(1'b0, 10, 0, "div");
    chk("div_lo_const", lo0, 32'hFFFFFFFD);
    chk("div_hi_const", hi0, 32'hFFFFFFFF);
    launch(1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0, 10, 0, "div_ovf");
    launch(1'b0, 2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done(1'b0, 10, 0, "div_negb");
    launch(1'b0, 2'b11, 32'hFFFFFFF9, 32'd10);
    wait_done(1'b0, 10, 0, "divu");
  endtask

  task automatic test_div_zero();
    write_hilo(1'b1, 1'b0, 32'h11111111);
    write_hilo(1'b0, 1'b1, 32'h22222222);
    chk("mthi", hi0, 32'h11111111);
    chk("mtlo", lo0, 32'h22222222);
    launch(1'b0, 2'b11, 32'd55, 32'd0);
    wait_done(1'b0, 10, 0, "divu_zero");
    launch(1'b0, 2'b10, 32'hFFFFFF00, 32'd0);
    wait_done(1'b0, 10, 0, "div_zero");
  endtask

  task automatic test_busy_ignore();
    launch(1'b0, 2'b00, 32'd5, 32'd7);
    tick(); tick();
    we_lo = 1'b1; wdata = 32'h0000DEAD; start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2;
    tick();
    we_lo = 1'b0; start = 1'b0;
    wait_done(1'b0, 5, 3, "busy_ignore");
    // Cancel a fresh MULT on its last busy cycle: prior result must survive
    launch(1'b0, 2'b00, 32'd100, 32'd100);
    repeat (4) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    void'(q0.pop_back());
    chk("cancel_busy", {31'h0, busy0}, 32'h0);
    chk("cancel_hi", hi0, mdl0[63:32]);
    chk("cancel_lo", lo0, mdl0[31:0]);
    tick();
    chk("cancel_busy2", {31'h0, busy0}, 32'h0);
  endtask

  task automatic test_idle_conflicts();
    // start with writes: writes dropped, op runs
    we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hCAFEF00D;
    launch(1'b0, 2'b01, 32'd6, 32'd9);
    we_hi = 1'b0; we_lo = 1'b0;
    wait_done(1'b0, 5, 0, "start_wins");
    // cancel in idle suppresses start and writes
    cancel = 1'b1; we_hi = 1'b1; wdata = 32'hBADBAD00; start = 1'b1;
    op = 2'b00; a = 32'd3; b = 32'd3;
    tick();
    cancel = 1'b0; we_hi = 1'b0; start = 1'b0;
    chk("idle_cancel_busy", {31'h0, busy0}, 32'h0);
    chk("idle_cancel_hi", hi0, mdl0[63:32]);
    chk("idle_cancel_lo", lo0, mdl0[31:0]);
  endtask

  task automatic test_sweep();
    do_reset();
    launch(1'b1, 2'b00, 32'd7, 32'd6);
    wait_done(1'b1, 1, 0, "sweep_mult");
    chk("sweep_mult_lo_const", lo1, 32'd42);
    launch(1'b1, 2'b10, 32'd100, 32'd7);
    wait_done(1'b1, 33, 0, "sweep_div");
    chk("sweep_div_lo_const", lo1, 32'd14);
    chk("sweep_div_hi_const", hi1, 32'd2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    cancel = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
    mdl0 = '0; mdl1 = '0;
    tick();
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_idle_conflicts();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
